// File: rtl/sync_sample_packer.sv
// Serial-to-parallel sample packer.
// Collects 2^PARALLEL_SAMPLE_BITS enabled samples into one wide word. Word
// boundaries are set by the sync marker, and the finished word is presented
// together with an aligned sync for the parallel arithmetic stage that follows.
module sync_sample_packer #(
  parameter int PARALLEL_SAMPLE_BITS = 3,
  parameter int INPUT_WIDTH          = 4
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                ce,
  input  logic                                                sync,
  input  logic [INPUT_WIDTH-1:0]                              din,
  output logic [(1<<PARALLEL_SAMPLE_BITS)*INPUT_WIDTH-1:0]    dout,
  output logic                                                dout_valid,
  output logic                                                sync_out,
  output logic                                                sync_err
);

  localparam int N  = 1 << PARALLEL_SAMPLE_BITS;
  localparam int DW = N * INPUT_WIDTH;
  localparam logic [PARALLEL_SAMPLE_BITS-1:0] CNT_ONE = PARALLEL_SAMPLE_BITS'(1);
  localparam logic [PARALLEL_SAMPLE_BITS-1:0] CNT_MAX = PARALLEL_SAMPLE_BITS'(N - 1);

  typedef enum logic {
    WAIT_SYNC = 1'b0,
    FILL      = 1'b1
  } state_t;

  state_t                          state_q, state_d;
  logic [PARALLEL_SAMPLE_BITS-1:0] cnt_q, cnt_d;
  logic [DW-1:0]                   asm_q, asm_d;
  logic [DW-1:0]                   dout_d;
  logic                            first_q, first_d;
  logic                            valid_d, sync_out_d, sync_err_d;

  // State, slot counter, assembly word and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_SYNC;
      cnt_q      <= '0;
      asm_q      <= '0;
      dout       <= '0;
      first_q    <= 1'b0;
      dout_valid <= 1'b0;
      sync_out   <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      dout       <= dout_d;
      first_q    <= first_d;
      dout_valid <= valid_d;
      sync_out   <= sync_out_d;
      sync_err   <= sync_err_d;
    end
  end

  // Next-state and output decode. Pulses default low; everything else holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    dout_d     = dout;
    first_d    = first_q;
    valid_d    = 1'b0;
    sync_out_d = 1'b0;
    sync_err_d = 1'b0;

    if (ce) begin
      case (state_q)
        WAIT_SYNC: begin
          if (sync) begin
            asm_d[INPUT_WIDTH-1:0] = din;
            cnt_d                  = CNT_ONE;
            first_d                = 1'b1;
            state_d                = FILL;
          end
        end

        FILL: begin
          if (sync) begin
            // A sync that lands on slot 0 is a clean realignment. Anywhere
            // else, the partial word is abandoned and flagged.
            sync_err_d             = (cnt_q != '0);
            asm_d[INPUT_WIDTH-1:0] = din;
            cnt_d                  = CNT_ONE;
            first_d                = 1'b1;
          end else begin
            asm_d[int'(cnt_q)*INPUT_WIDTH +: INPUT_WIDTH] = din;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_MAX) begin
              // The current sample is carried straight into the output word
              // so that the word appears one clock after its last sample.
              dout_d     = asm_d;
              valid_d    = 1'b1;
              sync_out_d = first_q;
              first_d    = 1'b0;
            end
          end
        end

        default: state_d = WAIT_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_sample_packer.sv
// Bench for sync_sample_packer: directed streams, a queue-based reference
// model compared every cycle, and literal expectations for the key words.
module tb_sync_sample_packer;

  localparam int P  = 3;
  localparam int W  = 4;
  localparam int N  = 1 << P;
  localparam int DW = N * W;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          ce   = 1'b0;
  logic          sync = 1'b0;
  logic [W-1:0]  din  = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, sync_out, sync_err;

  sync_sample_packer #(.PARALLEL_SAMPLE_BITS(P), .INPUT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sync(sync), .din(din),
    .dout(dout), .dout_valid(dout_valid), .sync_out(sync_out), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the samples accepted since the last sync form a list;
  // when that list reaches N entries it becomes the output word.
  logic [W-1:0]  m_slots[$];
  bit            m_synced, m_first;
  logic [DW-1:0] m_dout;
  bit            m_valid, m_sout, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slots.delete();
      m_synced = 0; m_first = 0;
      m_dout = '0; m_valid = 0; m_sout = 0; m_err = 0;
    end else begin
      m_valid = 0; m_sout = 0; m_err = 0;
      if (ce) begin
        if (sync) begin
          if (m_synced && m_slots.size() != 0) m_err = 1;
          m_slots.delete();
          m_slots.push_back(din);
          m_first  = 1;
          m_synced = 1;
        end else if (m_synced) begin
          m_slots.push_back(din);
          if (m_slots.size() == N) begin
            m_dout = '0;
            for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_slots[k];
            m_valid = 1;
            m_sout  = m_first;
            m_first = 0;
            m_slots.delete();
          end
        end
      end
    end
  end

  int n_valid = 0, n_sout = 0, n_err = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_dout", dout, m_dout);
      chk("cmp_dout_valid", 32'(dout_valid), 32'(m_valid));
      chk("cmp_sync_out", 32'(sync_out), 32'(m_sout));
      chk("cmp_sync_err", 32'(sync_err), 32'(m_err));
      n_valid += int'(dout_valid);
      n_sout  += int'(sync_out);
      n_err   += int'(sync_err);
    end
  end

  task automatic step(input logic c, input logic s, input logic [W-1:0] d);
    ce = c; sync = s; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  int v0, e0, s0;

  initial begin
    #1;
    chk("reset_dout", dout, 32'h0);
    chk("reset_valid", 32'(dout_valid), 32'h0);
    chk("reset_sync_out", 32'(sync_out), 32'h0);
    chk("reset_sync_err", 32'(sync_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // No sync yet: everything is discarded.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i));
    chk("ramp_no_valid", 32'(n_valid), 32'h0);
    chk("ramp_dout", dout, 32'h0);

    // First aligned word and its successor.
    step(1'b1, 1'b1, 4'h1);
    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0, 4'(i));
    chk("w1_dout", dout, 32'h87654321);
    chk("w1_model", m_dout, 32'h87654321);
    chk("w1_valid", 32'(dout_valid), 32'h1);
    chk("w1_sync_out", 32'(sync_out), 32'h1);
    step(1'b1, 1'b0, 4'h9);
    chk("w1_pulse_one_cycle", 32'(dout_valid), 32'h0);
    for (int i = 10; i <= 15; i++) step(1'b1, 1'b0, 4'(i));
    step(1'b1, 1'b0, 4'h0);
    chk("w2_dout", dout, 32'h0FEDCBA9);
    chk("w2_valid", 32'(dout_valid), 32'h1);
    chk("w2_sync_out", 32'(sync_out), 32'h0);

    // Same word with ce gaps; sync and din during gaps must be ignored.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, (i == 1), 4'(i));
      if (i != 8) step(1'b0, 1'b1, 4'hF);
    end
    chk("gap_dout", dout, 32'h87654321);
    chk("gap_valid", 32'(dout_valid), 32'h1);
    chk("gap_sync_out", 32'(sync_out), 32'h1);
    step(1'b0, 1'b0, 4'h3);
    chk("gap_hold_dout", dout, 32'h87654321);
    chk("gap_hold_valid", 32'(dout_valid), 32'h0);

    // Mid-word resync.
    v0 = n_valid; e0 = n_err;
    step(1'b1, 1'b1, 4'h1);
    step(1'b1, 1'b0, 4'h2);
    step(1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b1, 4'hA);
    chk("resync_err_pulse", 32'(sync_err), 32'h1);
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, 4'(i));
    chk("resync_dout", dout, 32'h7654321A);
    chk("resync_model", m_dout, 32'h7654321A);
    chk("resync_sync_out", 32'(sync_out), 32'h1);
    step(1'b0, 1'b0, 4'h0);
    chk("resync_err_count", 32'(n_err - e0), 32'h1);
    chk("resync_valid_count", 32'(n_valid - v0), 32'h1);

    // Asynchronous reset between edges, after five samples.
    step(1'b1, 1'b1, 4'h1);
    for (int i = 2; i <= 5; i++) step(1'b1, 1'b0, 4'(i));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dout", dout, 32'h0);
    chk("async_rst_valid", 32'(dout_valid), 32'h0);
    chk("async_rst_sync_out", 32'(sync_out), 32'h0);
    chk("async_rst_sync_err", 32'(sync_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    v0 = n_valid;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 6));
    step(1'b1, 1'b1, 4'h1);
    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0, 4'(i));
    chk("post_rst_dout", dout, 32'h87654321);
    chk("post_rst_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 4'h0);
    chk("post_rst_valid_count", 32'(n_valid - v0), 32'h1);

    // Sync exactly every N samples: every word flagged, no errors.
    s0 = n_sout; e0 = n_err;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < N; i++) step(1'b1, (i == 0), 4'(i + w));
    chk("b2b_last_dout", dout, 32'h98765432);
    step(1'b0, 1'b0, 4'h0);
    chk("b2b_sync_out_count", 32'(n_sout - s0), 32'h3);
    chk("b2b_no_err", 32'(n_err - e0), 32'h0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
